// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and defaults for the icache/dcache backing-memory arbiter.
// Holds the FSM encoding, the default starvation limit and the line-offset helper.
package cache_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } mem_arb_state_t;

  localparam int unsigned MEM_ARB_STARVE_LIMIT = 4;

  // Number of byte-offset address bits inside one cacheline.
  function automatic int unsigned line_off_bits(input int unsigned line_w);
    return $clog2(line_w / 8);
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache DFP and memory-port signal bundle; slave is the arbiter's view.
// Master is the caches-plus-memory-adapter side of the same wires.
interface cache_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
);
  logic [ADDR_W-1:0] icache_dfp_addr;
  logic              icache_dfp_read;
  logic [LINE_W-1:0] icache_dfp_rdata;
  logic              icache_dfp_resp;

  logic [ADDR_W-1:0] dcache_dfp_addr;
  logic              dcache_dfp_read;
  logic              dcache_dfp_write;
  logic [LINE_W-1:0] dcache_dfp_wdata;
  logic [LINE_W-1:0] dcache_dfp_rdata;
  logic              dcache_dfp_resp;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  icache_dfp_addr, icache_dfp_read,
    output icache_dfp_rdata, icache_dfp_resp,
    input  dcache_dfp_addr, dcache_dfp_read, dcache_dfp_write, dcache_dfp_wdata,
    output dcache_dfp_rdata, dcache_dfp_resp,
    output mem_addr, mem_read, mem_write, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output icache_dfp_addr, icache_dfp_read,
    input  icache_dfp_rdata, icache_dfp_resp,
    output dcache_dfp_addr, dcache_dfp_read, dcache_dfp_write, dcache_dfp_wdata,
    input  dcache_dfp_rdata, dcache_dfp_resp,
    input  mem_addr, mem_read, mem_write, mem_wdata,
    output mem_rdata, mem_resp
  );

endinterface

// File: rtl/cache_mem_arbiter_starve_ctr.sv
// Saturating count of dcache grants made while icache waits; clr wins over inc.
// Registered count, at_limit is a compare on the register (no added latency).
module mem_arb_starve_ctr #(
  parameter int unsigned LIMIT = 4,
  localparam int unsigned W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  logic [W-1:0] cnt;

  assign at_limit = (cnt == W'(LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one line-wide memory port between icache and dcache; dcache-first, owner held until mem_resp.
// One grant cycle plus one idle cycle per transaction; optional icache starvation guard under MEM_ARB_STARVE_GUARD_EN.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned LINE_W       = 256,
  parameter int unsigned STARVE_LIMIT = MEM_ARB_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_mem_arbiter_if.slave    bus
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_BUSY_I = BUSY_I;
  localparam logic [1:0] S_BUSY_D = BUSY_D;

  localparam int unsigned        OFF        = line_off_bits(LINE_W);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFF;

  logic [1:0]        state;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [LINE_W-1:0] mem_wdata_q;

  logic idle;
  logic d_req;
  logic i_req;
  logic grant_i;
  logic grant_d;
  logic i_resp;
  logic d_resp;

  assign idle  = (state == S_IDLE);
  assign d_req = bus.dcache_dfp_read | bus.dcache_dfp_write;
  assign i_req = bus.icache_dfp_read;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic at_limit;

  mem_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .inc      (grant_d & i_req),
    .clr      (grant_i),
    .at_limit (at_limit)
  );

  // Once icache has watched STARVE_LIMIT dcache grants go by, it takes the next slot.
  assign grant_i = idle & i_req & (~d_req | at_limit);
`else
  assign grant_i = idle & i_req & ~d_req;
`endif
  assign grant_d = idle & d_req & ~grant_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      mem_addr_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_d) begin
            // A simultaneous read+write from dcache is a writeback.
            state       <= S_BUSY_D;
            mem_addr_q  <= bus.dcache_dfp_addr & ALIGN_MASK;
            mem_write_q <= bus.dcache_dfp_write;
            mem_read_q  <= ~bus.dcache_dfp_write;
            mem_wdata_q <= bus.dcache_dfp_write ? bus.dcache_dfp_wdata : '0;
          end else if (grant_i) begin
            state       <= S_BUSY_I;
            mem_addr_q  <= bus.icache_dfp_addr & ALIGN_MASK;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b1;
            mem_wdata_q <= '0;
          end
        end
        S_BUSY_I, S_BUSY_D: begin
          if (bus.mem_resp) begin
            state       <= S_IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign i_resp = (state == S_BUSY_I) & bus.mem_resp;
  assign d_resp = (state == S_BUSY_D) & bus.mem_resp;

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign bus.icache_dfp_resp  = i_resp;
  assign bus.icache_dfp_rdata = (i_resp & mem_read_q) ? bus.mem_rdata : '0;
  assign bus.dcache_dfp_resp  = d_resp;
  assign bus.dcache_dfp_rdata = (d_resp & mem_read_q) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed stimulus, per-cycle compare against a transaction-level model.
module tb_cache_mem_arbiter;
  import cache_mem_arbiter_pkg::*;

  localparam int AW  = 32;
  localparam int LW  = 256;
  localparam int LIM = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit         GUARD    = 1'b1;
  localparam logic [5:0] EXP_HIST = 6'b000010;
`else
  localparam bit         GUARD    = 1'b0;
  localparam logic [5:0] EXP_HIST = 6'b000000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  cache_mem_arbiter #(
    .ADDR_W       (AW),
    .LINE_W       (LW),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: who owns the port and what the memory should be seeing.
  int              m_owner;   // 0 none, 1 icache, 2 dcache
  logic [AW-1:0]   m_addr;
  logic            m_rd, m_wr;
  logic [LW-1:0]   m_wdata;
  int              m_cnt;
  logic [15:0]     hist;      // 1 = icache grant, newest in bit 0
  int              n_grants;
  int              i_pulses, d_pulses;

  always @(posedge clk or negedge rst) begin : model
    bit d, i;
    int pick;
    if (!rst) begin
      m_owner = 0; m_addr = '0; m_rd = 0; m_wr = 0; m_wdata = '0; m_cnt = 0;
    end else if (m_owner == 0) begin
      d = bus.dcache_dfp_read || bus.dcache_dfp_write;
      i = bus.icache_dfp_read;
      pick = 0;
      if (i && GUARD && m_cnt == LIM) pick = 1;
      else if (d)                     pick = 2;
      else if (i)                     pick = 1;
      if (pick == 2) begin
        m_owner = 2;
        m_wr    = bus.dcache_dfp_write;
        m_rd    = !bus.dcache_dfp_write;
        m_addr  = bus.dcache_dfp_addr - (bus.dcache_dfp_addr % 32);
        m_wdata = bus.dcache_dfp_write ? bus.dcache_dfp_wdata : '0;
        if (i && m_cnt < LIM) m_cnt++;
        hist = {hist[14:0], 1'b0};
        n_grants++;
      end else if (pick == 1) begin
        m_owner = 1;
        m_wr    = 0;
        m_rd    = 1;
        m_addr  = bus.icache_dfp_addr - (bus.icache_dfp_addr % 32);
        m_wdata = '0;
        m_cnt   = 0;
        hist    = {hist[14:0], 1'b1};
        n_grants++;
      end
    end else if (bus.mem_resp) begin
      m_owner = 0; m_rd = 0; m_wr = 0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("mem_addr",  bus.mem_addr,  m_addr);
      chk("mem_read",  bus.mem_read,  m_rd);
      chk("mem_write", bus.mem_write, m_wr);
      chk("mem_wdata", bus.mem_wdata, m_wdata);
      chk("i_resp",  bus.icache_dfp_resp, (m_owner == 1) && bus.mem_resp);
      chk("d_resp",  bus.dcache_dfp_resp, (m_owner == 2) && bus.mem_resp);
      chk("i_rdata", bus.icache_dfp_rdata,
          ((m_owner == 1) && bus.mem_resp && m_rd) ? bus.mem_rdata : '0);
      chk("d_rdata", bus.dcache_dfp_rdata,
          ((m_owner == 2) && bus.mem_resp && m_rd) ? bus.mem_rdata : '0);
      if (bus.icache_dfp_resp) i_pulses++;
      if (bus.dcache_dfp_resp) d_pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a memory strobe, respond one cycle later with a one-cycle pulse.
  task automatic serve_one(input logic [7:0] tag);
    int w = 0;
    while (!(bus.mem_read || bus.mem_write) && w < 20) begin
      tick();
      w++;
    end
    chk("serve_wait", w < 20, 1'b1);
    tick();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = {32{tag}};
    tick();
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
  endtask

  logic [LW-1:0] line_a5;
  logic [LW-1:0] wline;
  int            g0;

  initial begin
    hist = '0; n_grants = 0; i_pulses = 0; d_pulses = 0;
    line_a5 = {32{8'hA5}};
    wline   = {8{32'h1234_5678}};
    bus.icache_dfp_addr  = '0; bus.icache_dfp_read  = 1'b0;
    bus.dcache_dfp_addr  = '0; bus.dcache_dfp_read  = 1'b0;
    bus.dcache_dfp_write = 1'b0; bus.dcache_dfp_wdata = '0;
    bus.mem_rdata = '0; bus.mem_resp = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Idle after reset, then a stray mem_resp.
    repeat (10) tick();
    chk("idle_read", bus.mem_read, 1'b0);
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = {8{32'hDEAD_BEEF}};
    tick();
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    tick();
    chk("stray_i_pulses", i_pulses, 0);
    chk("stray_d_pulses", d_pulses, 0);

    // Single icache read, memory answers 5 cycles after grant.
    bus.icache_dfp_read = 1'b1;
    bus.icache_dfp_addr = 32'h0000_1044;
    tick();
    chk("t2_addr", bus.mem_addr, 32'h0000_1040);
    chk("t2_read", bus.mem_read, 1'b1);
    repeat (4) tick();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = line_a5;
    #1;
    chk("t2_resp",  bus.icache_dfp_resp, 1'b1);
    chk("t2_rdata", bus.icache_dfp_rdata, line_a5);
    tick();
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    bus.icache_dfp_read = 1'b0;
    chk("t2_read_drop", bus.mem_read, 1'b0);
    chk("t2_pulses", i_pulses, 1);
    tick();

    // Icache read and dcache write together: dcache first.
    bus.icache_dfp_read  = 1'b1;
    bus.icache_dfp_addr  = 32'h0000_3080;
    bus.dcache_dfp_write = 1'b1;
    bus.dcache_dfp_addr  = 32'h0000_2000;
    bus.dcache_dfp_wdata = wline;
    tick();
    chk("t3_write", bus.mem_write, 1'b1);
    chk("t3_read",  bus.mem_read,  1'b0);
    chk("t3_addr",  bus.mem_addr,  32'h0000_2000);
    chk("t3_wdata", bus.mem_wdata, wline);
    repeat (2) tick();
    bus.mem_resp = 1'b1;
    tick();
    bus.mem_resp = 1'b0;
    bus.dcache_dfp_write = 1'b0;
    chk("t3_idle", bus.mem_write, 1'b0);
    tick();
    chk("t3_i_read", bus.mem_read, 1'b1);
    chk("t3_i_addr", bus.mem_addr, 32'h0000_3080);
    chk("t3_hist",   hist[1:0], 2'b01);
    tick();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = line_a5;
    tick();
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    bus.icache_dfp_read = 1'b0;
    tick();

    // Dcache hammering while icache waits.
    g0 = n_grants;
    bus.icache_dfp_read = 1'b1;
    bus.icache_dfp_addr = 32'h0000_4000;
    bus.dcache_dfp_read = 1'b1;
    bus.dcache_dfp_addr = 32'h0000_5020;
    for (int k = 0; k < 6; k++) serve_one(8'(k + 1));
    bus.icache_dfp_read = 1'b0;
    bus.dcache_dfp_read = 1'b0;
    chk("t4_grants", n_grants - g0, 6);
    chk("t4_hist", hist[5:0], EXP_HIST);
    repeat (3) tick();
    chk("t4_quiet", bus.mem_read, 1'b0);

    // Reset in the middle of a dcache writeback.
    bus.dcache_dfp_write = 1'b1;
    bus.dcache_dfp_addr  = 32'h0000_6000;
    bus.dcache_dfp_wdata = wline;
    tick();
    chk("t5_busy", bus.mem_write, 1'b1);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_rst_write", bus.mem_write, 1'b0);
    chk("t5_rst_read",  bus.mem_read,  1'b0);
    chk("t5_rst_addr",  bus.mem_addr,  32'h0);
    chk("t5_rst_wdata", bus.mem_wdata, '0);
    tick();
    bus.dcache_dfp_write = 1'b0;
    rst = 1'b1;
    bus.icache_dfp_read = 1'b1;
    bus.icache_dfp_addr = 32'h0000_7000;
    tick();
    chk("t5_i_read", bus.mem_read, 1'b1);
    chk("t5_i_addr", bus.mem_addr, 32'h0000_7000);
    tick();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = line_a5;
    #1;
    chk("t5_i_rdata", bus.icache_dfp_rdata, line_a5);
    tick();
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    bus.icache_dfp_read = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single cacheline-wide backing-memory port between the instruction cache and the data cache. Sits below both caches' DFP (downstream-facing) interfaces and above the memory adapter. Each transaction is latched and the owner is held until memory responds. Fixed dcache-first priority is used, with an optional starvation guard that protects instruction fetch.

## Interface
Parameters:
- ADDR_W, 32, address width
- LINE_W, 256, cacheline data width
- STARVE_LIMIT, 4, consecutive dcache grants tolerated while icache waits (guard enabled only)

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- icache_dfp_addr  input  ADDR_W  icache line address
- icache_dfp_read  input  1  icache read request, held until resp
- icache_dfp_rdata  output  LINE_W  returned line
- icache_dfp_resp  output  1  one-cycle completion pulse
- dcache_dfp_addr  input  ADDR_W  dcache line address
- dcache_dfp_read  input  1  dcache read request, held until resp
- dcache_dfp_write  input  1  dcache writeback request, held until resp
- dcache_dfp_wdata  input  LINE_W  writeback line
- dcache_dfp_rdata  output  LINE_W  returned line
- dcache_dfp_resp  output  1  one-cycle completion pulse
- mem_addr  output  ADDR_W  line-aligned address (low log2(LINE_W/8) bits forced 0)
- mem_read  output  1  read strobe, held until mem_resp
- mem_write  output  1  write strobe, held until mem_resp
- mem_wdata  output  LINE_W  write line
- mem_rdata  input  LINE_W  read line
- mem_resp  input  1  memory completion pulse

## Operation
- FSM states:
  - IDLE: no owner.
  - BUSY_I: icache owns the port.
  - BUSY_D: dcache owns the port.
- Arbitration in IDLE:
  - Dcache wins if dcache_dfp_read or dcache_dfp_write is asserted; otherwise icache wins if icache_dfp_read is asserted.
  - If dcache read and write are both asserted, the request is treated as a write.
- On grant, the address, read/write and wdata are registered into the mem_* outputs and the FSM moves to BUSY_x.
- In BUSY_x:
  - mem_* outputs are held constant.
  - Requester inputs are ignored, including the owner's.
  - New requests wait.
- On mem_resp in BUSY_x:
  - The owner's resp is driven for exactly that cycle; for reads, its rdata is driven combinationally from mem_rdata.
  - mem_read and mem_write clear at the next edge.
  - The FSM returns to IDLE.
- The non-owner's resp is always 0. The non-owner's rdata is '0.
- A mem_resp arriving in IDLE is ignored; no resp is forwarded.
- Reset, including mid-transaction:
  - State goes to IDLE.
  - All outputs go to 0.
  - The starvation counter goes to 0.
  - The in-flight transaction is dropped; the memory adapter is reset alongside.

## Timing
- Request seen in IDLE at edge N: mem_read/mem_write are asserted from cycle N+1.
- mem_resp at cycle M: requester resp is seen in cycle M (zero added response latency).
- Arbiter overhead per transaction: one cycle of grant plus one IDLE cycle after resp. Back-to-back grants are therefore at least 2 cycles apart.
- The requester must drop its request in the cycle after resp; the arbiter samples requests again only in IDLE.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined:
  - A counter increments on each dcache grant made while icache_dfp_read is asserted, saturating at STARVE_LIMIT.
  - The counter clears on every icache grant.
  - In IDLE, if the counter equals STARVE_LIMIT and icache_dfp_read is asserted, icache wins over dcache.
- Undefined: pure dcache-first priority; the counter and the STARVE_LIMIT logic are absent.

## Structure
- Package params: enum mem_arb_state_t {IDLE, BUSY_I, BUSY_D} and the default MEM_ARB_STARVE_LIMIT.
- Counter width is $clog2(STARVE_LIMIT+1).
- One sub-module: mem_arb_starve_ctr, a saturating counter with inc, clr and at_limit. It is instantiated only under MEM_ARB_STARVE_GUARD_EN.

## Test plan
- Reset released, no requests: all outputs 0 for 10 cycles; a stray mem_resp pulse produces no icache_dfp_resp or dcache_dfp_resp.
- Icache read at 0x0000_1044, memory responds 5 cycles later with line 0xA5..A5:
  - mem_addr = 0x0000_1040 and mem_read = 1 from the next cycle.
  - icache_dfp_resp is a single pulse carrying the line.
  - mem_read drops the cycle after.
- Icache read and dcache write to 0x0000_2000 asserted in the same cycle: dcache is served first with mem_write = 1 and wdata forwarded; icache is granted in the IDLE cycle after dcache's resp.
- Guard enabled, STARVE_LIMIT = 4, dcache requesting continuously and icache waiting: grants are D,D,D,D,I,D; the counter clears after I. With the guard undefined, icache is never granted while dcache requests.
- rst asserted while in BUSY_D: all outputs go 0 asynchronously; after release, a new icache request is granted normally.
